// File: rtl/skeeball_ball_ctrl.sv
// skeeball_ball_ctrl
//   Ball-supply controller for one skeeball lane. A start pulse loads a full
//   rack. Each launch hands out one ball. The ball in play is tracked until it
//   scores or times out as a gutter ball. The game ends once the last ball
//   has resolved. All state updates on the falling edge of clk.
//
//   Optional feature: define BONUS_BALL_EN to accept one extra ball per game
//   from the bonus pulse. In the default build bonus is ignored.
//
// Ports
//   clk           system clock (falling-edge active)
//   reset_n       asynchronous active-low reset
//   start         load a new game (any state, highest priority)
//   launch        lane-entry sensor pulse: one ball released
//   score         scoring-logic pulse: ball in play hit a target
//   bonus         award one extra ball (BONUS_BALL_EN builds only)
//   balls         thermometer count of balls remaining, LSB-justified
//   balls_left    binary count of balls remaining
//   ball_in_play  a launched ball is unresolved
//   gate_open     ball gate open, a launch is allowed
//   miss          one-cycle pulse: the ball in play timed out
//   game_over     one-cycle pulse: the last ball resolved
module skeeball_ball_ctrl #(
    parameter int NUM_BALLS    = 9,
    parameter int LANE_TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           launch,
    input  logic                           score,
    input  logic                           bonus,
    output logic [NUM_BALLS-1:0]           balls,
    output logic [$clog2(NUM_BALLS+1)-1:0] balls_left,
    output logic                           ball_in_play,
    output logic                           gate_open,
    output logic                           miss,
    output logic                           game_over
);

    localparam int CW = $clog2(NUM_BALLS + 1);
    localparam int TW = $clog2(LANE_TIMEOUT + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(NUM_BALLS);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(LANE_TIMEOUT);

    typedef enum logic [1:0] {IDLE, READY, IN_PLAY, DONE} state_t;

    state_t                state, state_n;
    logic [TW-1:0]         timer, timer_n;
    logic [NUM_BALLS-1:0]  balls_n;
    logic [CW-1:0]         balls_left_n;
    logic                  ball_in_play_n;
    logic                  gate_open_n;
    logic                  miss_n;
    logic                  game_over_n;
    logic                  timeout;

`ifdef BONUS_BALL_EN
    logic bonus_used, bonus_used_n;
    logic bonus_take;

    assign bonus_take = bonus && !bonus_used && (balls_left < FULL_COUNT) &&
                        ((state == READY) || (state == IN_PLAY));
`else
    logic unused_bonus;
    assign unused_bonus = bonus;
`endif

    assign timeout = (timer == TW'(1));

    always_comb begin
        state_n        = state;
        timer_n        = '0;
        balls_n        = balls;
        balls_left_n   = balls_left;
        ball_in_play_n = ball_in_play;
        miss_n         = 1'b0;
        game_over_n    = 1'b0;
`ifdef BONUS_BALL_EN
        bonus_used_n   = bonus_used;
`endif

        if (start) begin
            state_n        = READY;
            balls_n        = '1;
            balls_left_n   = FULL_COUNT;
            ball_in_play_n = 1'b0;
`ifdef BONUS_BALL_EN
            bonus_used_n   = 1'b0;
`endif
        end else begin
            case (state)
                READY: begin
                    if (launch) begin
                        balls_n        = balls >> 1;
                        balls_left_n   = balls_left - CW'(1);
                        ball_in_play_n = 1'b1;
                        timer_n        = TIMER_LOAD;
                        state_n        = IN_PLAY;
                    end
`ifdef BONUS_BALL_EN
                    // Applied after the launch so launch+bonus nets to no change.
                    if (bonus_take) begin
                        balls_n      = (balls_n << 1) | NUM_BALLS'(1);
                        balls_left_n = balls_left_n + CW'(1);
                        bonus_used_n = 1'b1;
                    end
`endif
                end
                IN_PLAY: begin
                    if (timer != '0) begin
                        timer_n = timer - TW'(1);
                    end
`ifdef BONUS_BALL_EN
                    // Applied before the resolution test so a bonus on the
                    // last ball's resolution keeps the game alive.
                    if (bonus_take) begin
                        balls_n      = (balls << 1) | NUM_BALLS'(1);
                        balls_left_n = balls_left + CW'(1);
                        bonus_used_n = 1'b1;
                    end
`endif
                    if (score || timeout) begin
                        ball_in_play_n = 1'b0;
                        timer_n        = '0;
                        miss_n         = !score;
                        if (balls_left_n == '0) begin
                            game_over_n = 1'b1;
                            state_n     = DONE;
                        end else begin
                            state_n = READY;
                        end
                    end
                end
                DONE: begin
                    balls_n      = '0;
                    balls_left_n = '0;
                end
                default: begin
                end
            endcase
        end

        gate_open_n = (state_n == READY);
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            timer        <= '0;
            balls        <= '0;
            balls_left   <= '0;
            ball_in_play <= 1'b0;
            gate_open    <= 1'b0;
            miss         <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            balls        <= balls_n;
            balls_left   <= balls_left_n;
            ball_in_play <= ball_in_play_n;
            gate_open    <= gate_open_n;
            miss         <= miss_n;
            game_over    <= game_over_n;
        end
    end

`ifdef BONUS_BALL_EN
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bonus_used <= 1'b0;
        end else begin
            bonus_used <= bonus_used_n;
        end
    end
`endif

endmodule

// File: tb/tb_skeeball_ball_ctrl.sv
// tb_skeeball_ball_ctrl
//   Directed bench for skeeball_ball_ctrl. The main instance uses the default
//   parameters (9 balls, 255-cycle timeout). Two further instances with
//   NUM_BALLS=1 and NUM_BALLS=16 (LANE_TIMEOUT=3) share a second set of inputs.
//   Inputs change 1 ns after the active (falling) edge; outputs are sampled there.
module tb_skeeball_ball_ctrl;

    logic clk = 1'b1;
    logic reset_n;
    logic start, launch, score, bonus;
    logic x_start, x_launch, x_score, x_bonus;

    logic [8:0]  balls;
    logic [3:0]  balls_left;
    logic        bip, gate, miss, over;

    logic [0:0]  balls1;
    logic [0:0]  left1;
    logic        bip1, gate1, miss1, over1;

    logic [15:0] balls16;
    logic [4:0]  left16;
    logic        bip16, gate16, miss16, over16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    skeeball_ball_ctrl #(.NUM_BALLS(9), .LANE_TIMEOUT(255)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .launch(launch),
        .score(score), .bonus(bonus), .balls(balls), .balls_left(balls_left),
        .ball_in_play(bip), .gate_open(gate), .miss(miss), .game_over(over)
    );

    skeeball_ball_ctrl #(.NUM_BALLS(1), .LANE_TIMEOUT(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(x_start), .launch(x_launch),
        .score(x_score), .bonus(x_bonus), .balls(balls1), .balls_left(left1),
        .ball_in_play(bip1), .gate_open(gate1), .miss(miss1), .game_over(over1)
    );

    skeeball_ball_ctrl #(.NUM_BALLS(16), .LANE_TIMEOUT(3)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(x_start), .launch(x_launch),
        .score(x_score), .bonus(x_bonus), .balls(balls16), .balls_left(left16),
        .ball_in_play(bip16), .gate_open(gate16), .miss(miss16), .game_over(over16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        reset_n = 1'b0;
        {start, launch, score, bonus} = '0;
        {x_start, x_launch, x_score, x_bonus} = '0;
        step(); step();
        check("rst_balls", 32'(balls), 32'h0);
        check("rst_left", 32'(balls_left), 32'd0);
        check("rst_flags", 32'({bip, gate, miss, over}), 32'h0);

        reset_n = 1'b1;
        step();
        start = 1'b1; step(); start = 1'b0;
        check("start_balls", 32'(balls), 32'h1FF);
        check("start_left", 32'(balls_left), 32'd9);
        check("start_gate", 32'(gate), 32'd1);
        check("start_bip", 32'(bip), 32'd0);

        launch = 1'b1; step(); launch = 1'b0;
        check("l1_balls", 32'(balls), 32'h0FF);
        check("l1_left", 32'(balls_left), 32'd8);
        check("l1_flags", 32'({bip, gate}), 32'b10);

        // Asynchronous reset in the middle of a cycle.
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_balls", 32'(balls), 32'h0);
        check("async_rst_flags", 32'({balls_left, bip, gate, miss, over}), 32'h0);
        #2 reset_n = 1'b1;
        step();
        check("idle_hold", 32'({balls, gate}), 32'h0);

        // Full game of 9 launch/score pairs.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            launch = 1'b1; step(); launch = 1'b0;
            check("game_balls", 32'(balls), (32'd1 << (8 - i)) - 32'd1);
            check("game_left", 32'(balls_left), 32'(8 - i));
            check("game_bip", 32'(bip), 32'd1);
            score = 1'b1; step(); score = 1'b0;
            check("game_res_bip", 32'(bip), 32'd0);
            check("game_res_miss", 32'(miss), 32'd0);
            check("game_over_pulse", 32'(over), (i == 8) ? 32'd1 : 32'd0);
            check("game_gate", 32'(gate), (i == 8) ? 32'd0 : 32'd1);
        end
        step();
        check("over_once", 32'(over), 32'd0);
        check("done_balls", 32'(balls), 32'h0);
        launch = 1'b1; step(); launch = 1'b0;
        check("done_launch", 32'({balls_left, bip, gate}), 32'h0);
        score = 1'b1; step(); score = 1'b0;
        check("done_score", 32'(over), 32'd0);

        // Timeout of a launched ball.
        start = 1'b1; step(); start = 1'b0;
        launch = 1'b1; step(); launch = 1'b0;
        seen = 1'b0;
        repeat (254) begin
            step();
            if (miss || !bip) seen = 1'b1;
        end
        check("to_early", 32'(seen), 32'd0);
        step();
        check("to_miss", 32'(miss), 32'd1);
        check("to_bip", 32'(bip), 32'd0);
        check("to_gate", 32'(gate), 32'd1);
        check("to_left", 32'(balls_left), 32'd8);
        step();
        check("to_miss_pulse", 32'(miss), 32'd0);

        // Score on the same cycle as the timeout.
        launch = 1'b1; step(); launch = 1'b0;
        repeat (254) step();
        score = 1'b1; step(); score = 1'b0;
        check("to_score_miss", 32'(miss), 32'd0);
        check("to_score_bip", 32'(bip), 32'd0);
        check("to_score_left", 32'(balls_left), 32'd7);

        // Extra launch while a ball is in play.
        launch = 1'b1; step();
        step(); launch = 1'b0;
        check("dbl_launch_left", 32'(balls_left), 32'd6);
        check("dbl_launch_bip", 32'(bip), 32'd1);
        score = 1'b1; step(); score = 1'b0;
        launch = 1'b1; step(); launch = 1'b0;
        score = 1'b1; step(); score = 1'b0;
        launch = 1'b1; step(); launch = 1'b0;
        check("four_left", 32'(balls_left), 32'd4);
        start = 1'b1; step(); start = 1'b0;
        check("restart_balls", 32'(balls), 32'h1FF);
        check("restart_left", 32'(balls_left), 32'd9);
        check("restart_flags", 32'({bip, miss, gate}), 32'b001);
        score = 1'b1; step(); score = 1'b0;
        check("ready_score", 32'({balls_left, gate, bip}), 32'({4'd9, 1'b1, 1'b0}));

        // NUM_BALLS=1 and NUM_BALLS=16 instances.
        x_start = 1'b1; step(); x_start = 1'b0;
        check("n1_start", 32'({balls1, left1, gate1}), 32'b111);
        check("n16_start", 32'({balls16, left16}), 32'({16'hFFFF, 5'd16}));
        x_launch = 1'b1; step(); x_launch = 1'b0;
        check("n1_launch", 32'({balls1, left1, bip1}), 32'b001);
        check("n16_launch", 32'({balls16, left16}), 32'({16'h7FFF, 5'd15}));
        step(); step();
        check("n1_bip", 32'(bip1), 32'd1);
        step();
        check("n1_res", 32'({miss1, over1, bip1}), 32'b110);
        check("n16_res", 32'({miss16, over16, gate16}), 32'b101);
        step();
        check("n1_done", 32'({over1, gate1}), 32'b00);
        for (int k = 1; k <= 15; k++) begin
            x_launch = 1'b1; step(); x_launch = 1'b0;
            check("n16_inv", 32'(balls16), (32'd1 << left16) - 32'd1);
            for (int c = 0; c < 3; c++) begin
                step();
                check("n16_inv", 32'(balls16), (32'd1 << left16) - 32'd1);
            end
            check("n16_over", 32'(over16), (k == 15) ? 32'd1 : 32'd0);
            check("n1_hold", 32'({balls1, left1}), 32'd0);
        end

`ifdef BONUS_BALL_EN
        // Main instance is in READY with a full rack.
        for (int i = 0; i < 8; i++) begin
            launch = 1'b1; step(); launch = 1'b0;
            score = 1'b1; step(); score = 1'b0;
        end
        launch = 1'b1; step(); launch = 1'b0;
        bonus = 1'b1; score = 1'b1; step(); bonus = 1'b0; score = 1'b0;
        check("bonus_left", 32'(balls_left), 32'd1);
        check("bonus_balls", 32'(balls), 32'h1);
        check("bonus_state", 32'({gate, over, bip}), 32'b100);
        launch = 1'b1; step(); launch = 1'b0;
        bonus = 1'b1; score = 1'b1; step(); bonus = 1'b0; score = 1'b0;
        check("bonus2_over", 32'(over), 32'd1);
        check("bonus2_left", 32'({balls_left, gate}), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/skeeball_ball_ctrl.md
Name: skeeball_ball_ctrl

Overview:
Parametrised ball-supply controller for one skeeball lane: loads a full rack at game start, hands out one ball per launch, and tracks each ball until it scores or times out as a gutter ball. Ends the game after the last ball resolves.
Outputs a thermometer ball display plus a binary count for the scoring and display logic, and drives the ball-gate solenoid.

Parameters:
NUM_BALLS, 9, balls per game (1..31); thermometer width.
LANE_TIMEOUT, 255, clk cycles allowed from launch to score before the ball counts as a miss (>=1).

Ports:
clk  input  1  system clock; all state updates on falling edge, matching the rest of the lane logic.
reset_n  input  1  asynchronous active-low reset.
start  input  1  sync pulse: load a new game (valid in any state).
launch  input  1  sync pulse from the lane-entry sensor: one ball released.
score  input  1  sync pulse from the scoring logic: the ball in play landed in a target.
bonus  input  1  sync pulse: award one extra ball (used only with the optional feature).
balls  output  NUM_BALLS  thermometer count of balls remaining, LSB-justified.
balls_left  output  $clog2(NUM_BALLS+1)  binary count of balls remaining.
ball_in_play  output  1  a launched ball is unresolved.
gate_open  output  1  ball gate open (a launch is allowed).
miss  output  1  one-cycle pulse: the ball in play timed out.
game_over  output  1  one-cycle pulse: the last ball resolved.

Behaviour:
- Reset (async assert, deassert synchronised externally): state IDLE; balls=0, balls_left=0, ball_in_play=0, gate_open=0, miss=0, game_over=0, timer=0, bonus_used=0.
- States: IDLE, READY, IN_PLAY, DONE. All outputs are registered.
- start, any state, highest priority: balls=all ones, balls_left=NUM_BALLS, timer=0, ball_in_play=0, bonus_used=0, next READY. A ball in play is discarded with no miss pulse.
- READY: gate_open=1. When launch=1: balls<=balls>>1, balls_left-1, ball_in_play=1, timer<=LANE_TIMEOUT, next IN_PLAY.
- IN_PLAY: gate_open=0. Launch is ignored; extra launches do not change the count. The timer decrements each cycle.
- IN_PLAY resolution: score=1, or timer==1 when decrementing, resolves the ball.
  - On resolution, ball_in_play=0.
  - A timeout resolution gives miss=1 for one cycle.
  - Score and timeout in the same cycle count as a score, with no miss.
  - If balls_left==0 after resolution: game_over=1 for one cycle, next DONE. Otherwise next READY.
- Ball latency: the count decrements on the launch edge, not on resolution. Resolution is visible on the next falling edge.
- DONE: gate_open=0. balls=0 and balls_left=0 are held until start. launch, score and bonus are ignored.
- IDLE: all inputs except start are ignored. A score in READY or IDLE is ignored (spurious sensor).
- Invariant: balls == (1<<balls_left)-1 at all times.
- Timer width is $clog2(LANE_TIMEOUT+1). It never wraps: it saturates at 0 outside IN_PLAY.

Optional Feature:
Macro BONUS_BALL_EN.
- Defined: the bonus pulse is accepted in READY or IN_PLAY when bonus_used=0 and balls_left<NUM_BALLS.
  - Effect: balls<=(balls<<1)|1, balls_left+1, bonus_used=1.
  - If bonus arrives in the same cycle as the resolution of the last ball, DONE is not entered: next READY with balls_left=1, and no game_over.
  - If bonus arrives in the same cycle as a launch in READY, the count nets to unchanged and IN_PLAY is entered.
  - Only one bonus is accepted per game.
- Undefined: the bonus port exists but is ignored; bonus_used logic is absent.

Test Plan:
- reset_n=0 mid-game -> all outputs 0, state IDLE; start after release -> balls=9'h1FF, balls_left=9, gate_open=1.
- Full game, 9 launch/score pairs -> balls steps 1FF,0FF,07F,...,001,000; game_over pulses exactly once after the 9th score; the state then holds DONE.
- Launch with no score, LANE_TIMEOUT=255 -> miss pulses 255 cycles after launch and ball_in_play falls; score arriving on that same cycle -> no miss.
- Second launch during IN_PLAY -> balls_left unchanged; start during IN_PLAY with 4 balls left -> balls=1FF, ball_in_play=0, no miss.
- Parameter sweep NUM_BALLS=1 and 16 -> a single-ball game ends after one resolution; the 16-bit thermometer invariant holds every cycle.
- BONUS_BALL_EN, bonus on the cycle the last ball scores -> balls_left=1, state READY, no game_over; a second bonus is ignored.
